if_fetch_stage: RTL and testbench

- Instruction-fetch stage directly upstream of the jump/branch unit.
- Owns the architectural PC register and issues single-outstanding reads to instruction memory using a valid/grant request and a response strobe.
- Presents the fetched instruction and its PC to decode through a one-entry IF/ID register with a valid/ready handshake.
- Consumes the redirect (PcSel, NextPC) produced by the jump/branch unit and squashes wrong-path fetches.

---
 rtl/if_fetch_stage.sv | 166 ++++++++++++++++
 tb/tb_if_fetch_stage.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage
//   Instruction-fetch stage feeding decode and the jump/branch unit. Owns the
//   architectural PC, keeps a single read outstanding to instruction memory,
//   and hands each fetched word to decode through a one-entry IF/ID register
//   backed by a one-entry skid buffer. A redirect from the jump/branch unit
//   reloads the PC and squashes any wrong-path fetch or buffered word.
//
// Ports:
//   clk, rst_n      clock (rising edge) / asynchronous active-low reset
//   Redirect        PcSel from the jump/branch unit
//   RedirectPC      NextPC target; low two bits ignored (word aligned)
//   IdReady         decode consumes IF/ID contents this cycle
//   ImemReq/Addr    fetch request valid / byte address (always the PC)
//   ImemGnt         memory accepts the request this cycle
//   ImemRspValid    read data valid, one or more cycles after the grant
//   ImemRspData     fetched instruction word
//   IfIdValid/Instr/PC  IF/ID register contents presented to decode
// ---------------------------------------------------------------------------
module if_fetch_stage #(
   parameter int              PC_W     = 9,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            Redirect,
   input  logic [31:0]     RedirectPC,
   input  logic            IdReady,
   output logic            ImemReq,
   output logic [PC_W-1:0] ImemAddr,
   input  logic            ImemGnt,
   input  logic            ImemRspValid,
   input  logic [31:0]     ImemRspData,
   output logic            IfIdValid,
   output logic [31:0]     IfIdInstr,
   output logic [PC_W-1:0] IfIdPC
);

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,   // request presented to memory
      S_WAIT = 2'd1,   // granted, waiting for the response
      S_HOLD = 2'd2,   // response parked in the skid, decode stalled
      S_DROP = 2'd3    // outstanding response belongs to a squashed path
   } state_e;

   state_e          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [PC_W-1:0] req_pc_q, req_pc_d;
   logic            ifid_valid_q, ifid_valid_d;
   logic [31:0]     ifid_instr_q, ifid_instr_d;
   logic [PC_W-1:0] ifid_pc_q, ifid_pc_d;
   logic [31:0]     skid_instr_q, skid_instr_d;
   logic [PC_W-1:0] skid_pc_q, skid_pc_d;

   logic [PC_W-1:0] redirect_pc;
   logic            ifid_free;
   logic            unused_redirect_bits;

   assign redirect_pc          = {RedirectPC[PC_W-1:2], 2'b00};
   assign unused_redirect_bits = ^{RedirectPC[31:PC_W], RedirectPC[1:0]};

   // IF/ID can take a new word if empty or being drained by decode this cycle.
   assign ifid_free = !ifid_valid_q || IdReady;

   // Held low during reset so memory never sees a request from a reset stage.
   assign ImemReq   = rst_n && (state_q == S_REQ);
   assign ImemAddr  = pc_q;
   assign IfIdValid = ifid_valid_q;
   assign IfIdInstr = ifid_instr_q;
   assign IfIdPC    = ifid_pc_q;

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      req_pc_d     = req_pc_q;
      ifid_valid_d = ifid_valid_q;
      ifid_instr_d = ifid_instr_q;
      ifid_pc_d    = ifid_pc_q;
      skid_instr_d = skid_instr_q;
      skid_pc_d    = skid_pc_q;

      if (ifid_valid_q && IdReady) begin
         ifid_valid_d = 1'b0;
      end

      unique case (state_q)
         S_REQ: begin
            if (ImemGnt) begin
               req_pc_d = pc_q;
               pc_d     = pc_q + PC_W'(4);
               state_d  = S_WAIT;
            end
         end
         S_WAIT: begin
            if (ImemRspValid) begin
               if (ifid_free) begin
                  ifid_valid_d = 1'b1;
                  ifid_instr_d = ImemRspData;
                  ifid_pc_d    = req_pc_q;
                  state_d      = S_REQ;
               end else begin
                  skid_instr_d = ImemRspData;
                  skid_pc_d    = req_pc_q;
                  state_d      = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            // IF/ID is necessarily valid here; the skid refills it on drain.
            if (IdReady) begin
               ifid_valid_d = 1'b1;
               ifid_instr_d = skid_instr_q;
               ifid_pc_d    = skid_pc_q;
               state_d      = S_REQ;
            end
         end
         S_DROP: begin
            if (ImemRspValid) begin
               state_d = S_REQ;
            end
         end
         default: state_d = S_REQ;
      endcase

      // Redirect wins over everything above. A grant accepted in the same
      // cycle still leaves a response in flight, which DROP absorbs.
      if (Redirect) begin
         pc_d         = redirect_pc;
         ifid_valid_d = 1'b0;
         ifid_instr_d = ifid_instr_q;
         ifid_pc_d    = ifid_pc_q;
         unique case (state_q)
            S_REQ:   state_d = ImemGnt      ? S_DROP : S_REQ;
            S_WAIT:  state_d = ImemRspValid ? S_REQ  : S_DROP;
            S_HOLD:  state_d = S_REQ;
            S_DROP:  state_d = S_DROP;
            default: state_d = S_REQ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_REQ;
         pc_q         <= RESET_PC;
         req_pc_q     <= '0;
         ifid_valid_q <= 1'b0;
         ifid_instr_q <= NOP;
         ifid_pc_q    <= '0;
         skid_instr_q <= NOP;
         skid_pc_q    <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         req_pc_q     <= req_pc_d;
         ifid_valid_q <= ifid_valid_d;
         ifid_instr_q <= ifid_instr_d;
         ifid_pc_q    <= ifid_pc_d;
         skid_instr_q <= skid_instr_d;
         skid_pc_q    <= skid_pc_d;
      end
   end

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;

   logic        clk;
   logic        rst_n;
   logic        Redirect;
   logic [31:0] RedirectPC;
   logic        IdReady;
   logic        ImemReq;
   logic [8:0]  ImemAddr;
   logic        ImemGnt;
   logic        ImemRspValid;
   logic [31:0] ImemRspData;
   logic        IfIdValid;
   logic [31:0] IfIdInstr;
   logic [8:0]  IfIdPC;

   logic        gnt_en;
   int          lat;
   int          checks = 0;
   int          errors = 0;

   typedef struct packed {
      logic [8:0]  pc;
      logic [31:0] instr;
   } exp_t;
   exp_t sb_q[$];

   if_fetch_stage #(.PC_W(9), .RESET_PC(9'h000)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .Redirect     (Redirect),
      .RedirectPC   (RedirectPC),
      .IdReady      (IdReady),
      .ImemReq      (ImemReq),
      .ImemAddr     (ImemAddr),
      .ImemGnt      (ImemGnt),
      .ImemRspValid (ImemRspValid),
      .ImemRspData  (ImemRspData),
      .IfIdValid    (IfIdValid),
      .IfIdInstr    (IfIdInstr),
      .IfIdPC       (IfIdPC)
   );

   assign ImemGnt = ImemReq & gnt_en;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push(input logic [8:0] pc, input logic [31:0] instr);
      exp_t e;
      e.pc    = pc;
      e.instr = instr;
      sb_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_req(input logic [8:0] exp_addr, input string name);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!ImemReq && n < 30);
      if (!ImemReq) begin
         checks++;
         errors++;
         $display("FAIL %s: no request within 30 cycles, expected addr %h", name, exp_addr);
      end else begin
         chk(name, 32'(ImemAddr), 32'(exp_addr));
      end
   endtask

   task automatic wait_valid(input string name);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!IfIdValid && n < 30);
      if (!IfIdValid) begin
         checks++;
         errors++;
         $display("FAIL %s: IfIdValid not seen within 30 cycles, expected 1", name);
      end
   endtask

   task automatic do_reset(input logic ready);
      tick();
      rst_n      = 1'b0;
      IdReady    = ready;
      gnt_en     = 1'b1;
      Redirect   = 1'b0;
      RedirectPC = 32'h0;
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   // Instruction memory: one outstanding read, response 'lat' cycles after grant.
   initial begin : mem_model
      logic       pend;
      int         cnt;
      logic [8:0] paddr;
      pend = 1'b0;
      cnt = 0;
      paddr = '0;
      ImemRspValid = 1'b0;
      ImemRspData  = 32'h0;
      forever begin
         @(negedge clk);
         if (rst_n && ImemReq && ImemGnt) begin
            pend  = 1'b1;
            cnt   = lat;
            paddr = ImemAddr;
         end
         @(posedge clk);
         #1;
         ImemRspValid = 1'b0;
         if (!rst_n) begin
            pend = 1'b0;
         end else if (pend) begin
            cnt--;
            if (cnt == 0) begin
               ImemRspValid = 1'b1;
               ImemRspData  = 32'hC0DE_0000 | {23'b0, paddr};
               pend = 1'b0;
            end
         end
      end
   end

   // Scoreboard monitor: every IF/ID transfer to decode is compared in order.
   always @(negedge clk) begin
      if (rst_n && IfIdValid && IdReady && !Redirect) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: got pc %h instr %h, expected no transfer", IfIdPC, IfIdInstr);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("sb_pc", 32'(IfIdPC), 32'(e.pc));
            chk("sb_instr", IfIdInstr, e.instr);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n      = 1'b1;
      Redirect   = 1'b0;
      RedirectPC = 32'h0;
      IdReady    = 1'b1;
      gnt_en     = 1'b1;
      lat        = 1;
      #1 rst_n = 1'b0;
      #2;
      chk("rst_req", 32'(ImemReq), 32'd0);
      chk("rst_addr", 32'(ImemAddr), 32'h000);
      chk("rst_valid", 32'(IfIdValid), 32'd0);
      chk("rst_instr", IfIdInstr, 32'h0000_0013);
      chk("rst_pc", 32'(IfIdPC), 32'h000);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;

      // Streaming with a 1-cycle memory and decode always ready
      push(9'h000, 32'hC0DE_0000);
      push(9'h004, 32'hC0DE_0004);
      push(9'h008, 32'hC0DE_0008);
      wait_req(9'h000, "p1_req0");
      wait_valid("p1_vld1");
      chk("p1_req4", 32'(ImemReq), 32'd1);
      chk("p1_addr4", 32'(ImemAddr), 32'h004);
      @(negedge clk);
      chk("p1_gap1", 32'(IfIdValid), 32'd0);
      @(negedge clk);
      chk("p1_vld2", 32'(IfIdValid), 32'd1);
      chk("p1_addr8", 32'(ImemAddr), 32'h008);
      tick();
      gnt_en = 1'b0;
      @(negedge clk);
      chk("p1_gap2", 32'(IfIdValid), 32'd0);
      @(negedge clk);
      chk("p1_vld3", 32'(IfIdValid), 32'd1);
      chk("p1_pc8", 32'(IfIdPC), 32'h008);
      repeat (3) tick();

      // Decode stalled: IF/ID holds, second word parks in the skid
      do_reset(1'b0);
      push(9'h000, 32'hC0DE_0000);
      push(9'h004, 32'hC0DE_0004);
      push(9'h008, 32'hC0DE_0008);
      wait_valid("p2_vld");
      begin
         int bad = 0;
         for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge clk);
            if (!IfIdValid || IfIdPC !== 9'h000 || IfIdInstr !== 32'hC0DE_0000) bad++;
         end
         chk("p2_hold_stable_bad_cycles", 32'(bad), 32'd0);
         chk("p2_hold_noreq", 32'(ImemReq), 32'd0);
      end
      tick();
      IdReady = 1'b1;
      wait_req(9'h008, "p2_req8");
      tick();
      gnt_en = 1'b0;
      repeat (6) tick();

      // Redirect to 0x40 while waiting (2-cycle memory) for 0x008
      lat = 2;
      do_reset(1'b1);
      push(9'h000, 32'hC0DE_0000);
      push(9'h004, 32'hC0DE_0004);
      push(9'h040, 32'hC0DE_0040);
      wait_req(9'h000, "p3_req0");
      wait_req(9'h004, "p3_req4");
      wait_req(9'h008, "p3_req8");
      tick();
      Redirect   = 1'b1;
      RedirectPC = 32'h0000_0040;
      tick();
      Redirect   = 1'b0;
      RedirectPC = 32'h0;
      @(negedge clk);
      chk("p3_drop_valid", 32'(IfIdValid), 32'd0);
      chk("p3_drop_noreq", 32'(ImemReq), 32'd0);
      wait_req(9'h040, "p3_req40");
      tick();
      gnt_en = 1'b0;
      wait_valid("p3_vld40");
      chk("p3_pc40", 32'(IfIdPC), 32'h040);
      repeat (4) tick();
      lat = 1;

      // Redirect coincident with the grant for 0x00C, then PC wrap at 0x1FC
      do_reset(1'b1);
      push(9'h000, 32'hC0DE_0000);
      push(9'h004, 32'hC0DE_0004);
      push(9'h008, 32'hC0DE_0008);
      wait_req(9'h000, "p4_req0");
      wait_req(9'h004, "p4_req4");
      wait_req(9'h008, "p4_req8");
      tick();
      gnt_en = 1'b0;
      wait_req(9'h00C, "p4_reqC");
      repeat (3) tick();
      gnt_en     = 1'b1;
      Redirect   = 1'b1;
      RedirectPC = 32'h0000_01F3;
      tick();
      Redirect   = 1'b0;
      RedirectPC = 32'h0;
      @(negedge clk);
      chk("p4_drop_noreq", 32'(ImemReq), 32'd0);
      chk("p4_pc_1f0", 32'(ImemAddr), 32'h1F0);
      chk("p4_drop_valid", 32'(IfIdValid), 32'd0);
      push(9'h1F0, 32'hC0DE_01F0);
      push(9'h1F4, 32'hC0DE_01F4);
      push(9'h1F8, 32'hC0DE_01F8);
      push(9'h1FC, 32'hC0DE_01FC);
      push(9'h000, 32'hC0DE_0000);
      wait_req(9'h1F0, "p4_req1f0");
      wait_req(9'h1F4, "p4_req1f4");
      wait_req(9'h1F8, "p4_req1f8");
      wait_req(9'h1FC, "p4_req1fc");
      wait_req(9'h000, "p5_wrap");
      tick();
      gnt_en = 1'b0;
      repeat (6) tick();

      // Reset asserted mid-fetch with a valid word in IF/ID
      do_reset(1'b0);
      wait_valid("p6_vld");
      tick();
      chk("p6_pre_valid", 32'(IfIdValid), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("p6_rst_valid", 32'(IfIdValid), 32'd0);
      chk("p6_rst_instr", IfIdInstr, 32'h0000_0013);
      chk("p6_rst_pc", 32'(IfIdPC), 32'h000);
      chk("p6_rst_req", 32'(ImemReq), 32'd0);
      repeat (2) @(posedge clk);
      #2;
      rst_n   = 1'b1;
      IdReady = 1'b1;
      push(9'h000, 32'hC0DE_0000);
      wait_req(9'h000, "p6_first_req");
      tick();
      gnt_en = 1'b0;
      repeat (6) tick();

      chk("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
